// File: rtl/tdm_pkg.sv
// Shared definitions for the two-channel TDM receive path: state encoding,
// the default word width and the frame-length helper.
package tdm_pkg;

  // Default bits per channel word.
  localparam int TDM_WIDTH_DEFAULT = 8;

  // Receiver framing states. The frame-boundary check is CH0 with a zero bit
  // count, a combination that only occurs right after a channel 1 word.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    CH0  = 2'd1,
    CH1  = 2'd2
  } tdm_state_e;

  // A frame carries one word per channel.
  function automatic int frame_len(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/tdm_sipo.sv
// Serial-in parallel-out word assembler, MSB first. Only the first WIDTH-1
// bits are stored; the final bit is appended from din_i so that a complete
// word is available on the same edge that samples its last bit.
module tdm_sipo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic             clr_i,
  input  logic             din_i,
  output logic [WIDTH-1:0] par_o
);

  logic [WIDTH-2:0] sr_q;

  // Stored bits followed by the bit currently on the line.
  assign par_o = {sr_q, din_i};

  // Shift left with din entering at the LSB; clear together with a shift
  // starts a fresh word whose first bit is din.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (shift_en_i) begin
      if (clr_i) begin
        sr_q <= (WIDTH-1)'(din_i);
      end else begin
        sr_q <= par_o[WIDTH-2:0];
      end
    end else if (clr_i) begin
      sr_q <= '0;
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: hunts for a sync-marked frame, deserializes
// alternating channel 0 / channel 1 words and presents each on its own
// registered output with a one-cycle valid strobe. Misplaced or missing sync
// pulses frame_err; a misplaced sync resynchronizes at once, a missing one
// drops back to HUNT.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int WIDTH = TDM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             valid0,
  output logic             valid1,
  output logic             frame_err,
  output logic             locked
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  tdm_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] out0_q;
  logic [WIDTH-1:0] out1_q;
  logic             valid0_q;
  logic             valid1_q;
  logic             frame_err_q;
  logic             locked_q;

  logic [WIDTH-1:0] word;
  logic             boundary;
  logic             sipo_shift;
  logic             sipo_clr;

  // First strobed bit after a channel 1 word: a sync is expected here.
  assign boundary = (state_q == CH0) && (cnt_q == '0);

  // Shift-register control: a sync always starts a new word; inside a frame
  // every other strobed bit is shifted, except the boundary bit which is
  // discarded when sync is missing.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sipo_shift = 1'b0;
    sipo_clr   = 1'b0;
    if (en) begin
      sipo_clr   = sync || boundary;
      sipo_shift = sync || ((state_q != HUNT) && !boundary);
    end
  end

  tdm_sipo #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en_i(sipo_shift),
    .clr_i     (sipo_clr),
    .din_i     (din),
    .par_o     (word)
  );

  // Framing FSM with bit counter and registered outputs; nothing moves on
  // cycles without a bit strobe except the pulses returning low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      frame_err_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised only on
      // the edge that produces them, giving exactly one cycle regardless of en.
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      frame_err_q <= 1'b0;
      if (en) begin
        unique case (state_q)
          HUNT: begin
            if (sync) begin
              state_q  <= CH0;
              cnt_q    <= ONE;
              locked_q <= 1'b1;
            end
          end
          CH0, CH1: begin
            if (sync) begin
              // Sync is legal only at the frame boundary; either way this bit
              // is the new channel 0 MSB.
              frame_err_q <= !boundary;
              state_q     <= CH0;
              cnt_q       <= ONE;
            end else if (boundary) begin
              frame_err_q <= 1'b1;
              state_q     <= HUNT;
              cnt_q       <= '0;
              locked_q    <= 1'b0;
            end else if (cnt_q != LAST) begin
              cnt_q <= cnt_q + ONE;
            end else begin
              cnt_q <= '0;
              if (state_q == CH0) begin
                out0_q   <= word;
                valid0_q <= 1'b1;
                state_q  <= CH1;
              end else begin
                out1_q   <= word;
                valid1_q <= 1'b1;
                state_q  <= CH0;
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign valid0    = valid0_q;
  assign valid1    = valid1_q;
  assign frame_err = frame_err_q;
  assign locked    = locked_q;

endmodule
